// File: rtl/placement_registry.sv
// placement_registry: nest/patch placement store with collision probe,
// per-patch sugar harvest and per-nest food deposit counters.
module placement_registry #(
   parameter int NEST_num       = 4,
   parameter int SUGARPATCH_num = 8,
   parameter int X_bits         = 8,
   parameter int Y_bits         = 7,
   parameter int COLLIDE_R      = 3,
   parameter int SUGAR_bits     = 8,
   parameter int SUGAR_init     = 200,
   parameter int FOOD_bits      = 12,
   localparam int NW = (NEST_num > 1) ? $clog2(NEST_num) : 1,
   localparam int PW = (SUGARPATCH_num > 1) ? $clog2(SUGARPATCH_num) : 1
) (
   input  logic                                  setup_clk,
   input  logic                                  RESET_SIM_n,
   input  logic                                  nest_wr,
   input  logic [NW-1:0]                         nest_id,
   input  logic [X_bits-1:0]                     nest_setup_x,
   input  logic [Y_bits-1:0]                     nest_setup_y,
   input  logic                                  patch_wr,
   input  logic [PW-1:0]                         patch_id,
   input  logic [X_bits-1:0]                     patch_setup_x,
   input  logic [Y_bits-1:0]                     patch_setup_y,
   input  logic [X_bits-1:0]                     collide_x,
   input  logic [Y_bits-1:0]                     collide_y,
   output logic                                  collision,
   output logic [NEST_num-1:0][X_bits-1:0]       nests_X,
   output logic [NEST_num-1:0][Y_bits-1:0]       nests_Y,
   input  logic                                  harvest_req,
   input  logic [PW-1:0]                         harvest_patch,
   output logic                                  harvest_ack,
   output logic                                  harvest_ok,
   input  logic                                  deposit_req,
   input  logic [NW-1:0]                         deposit_nest,
   output logic [SUGARPATCH_num-1:0]             patch_empty,
   output logic [NEST_num-1:0][FOOD_bits-1:0]    nest_food
);

   localparam logic [X_bits:0]     RX    = (X_bits+1)'(COLLIDE_R);
   localparam logic [Y_bits:0]     RY    = (Y_bits+1)'(COLLIDE_R);
   localparam logic [SUGAR_bits-1:0] S_INIT = SUGAR_bits'(SUGAR_init);
   localparam logic [FOOD_bits-1:0]  F_MAX  = '1;

   logic [NEST_num-1:0]                       r_nest_v;
   logic [NEST_num-1:0][X_bits-1:0]           r_nest_x;
   logic [NEST_num-1:0][Y_bits-1:0]           r_nest_y;
   logic [NEST_num-1:0][FOOD_bits-1:0]        r_food;
   logic [SUGARPATCH_num-1:0]                 r_patch_v;
   logic [SUGARPATCH_num-1:0][X_bits-1:0]     r_patch_x;
   logic [SUGARPATCH_num-1:0][Y_bits-1:0]     r_patch_y;
   logic [SUGARPATCH_num-1:0][SUGAR_bits-1:0] r_sugar;
   logic                                      r_hack;
   logic                                      r_hok;

   logic                                      w_coll;
   logic                                      w_hok;
   logic [SUGARPATCH_num-1:0]                 w_empty;

   // Chebyshev-distance test of the candidate against every valid entry.
   always_comb begin
      logic [X_bits:0] dx;
      logic [Y_bits:0] dy;
      w_coll = 1'b0;
      dx     = '0;
      dy     = '0;
      for (int i = 0; i < NEST_num; i++) begin
         dx = (collide_x >= r_nest_x[i]) ?
              {1'b0, collide_x} - {1'b0, r_nest_x[i]} :
              {1'b0, r_nest_x[i]} - {1'b0, collide_x};
         dy = (collide_y >= r_nest_y[i]) ?
              {1'b0, collide_y} - {1'b0, r_nest_y[i]} :
              {1'b0, r_nest_y[i]} - {1'b0, collide_y};
         if (r_nest_v[i] && dx <= RX && dy <= RY) w_coll = 1'b1;
      end
      for (int i = 0; i < SUGARPATCH_num; i++) begin
         dx = (collide_x >= r_patch_x[i]) ?
              {1'b0, collide_x} - {1'b0, r_patch_x[i]} :
              {1'b0, r_patch_x[i]} - {1'b0, collide_x};
         dy = (collide_y >= r_patch_y[i]) ?
              {1'b0, collide_y} - {1'b0, r_patch_y[i]} :
              {1'b0, r_patch_y[i]} - {1'b0, collide_y};
         if (r_patch_v[i] && dx <= RX && dy <= RY) w_coll = 1'b1;
      end
   end

   // Harvest succeeds only on a valid, non-empty patch not being rewritten.
   always_comb begin
      w_hok   = 1'b0;
      w_empty = '0;
      for (int i = 0; i < SUGARPATCH_num; i++) begin
         w_empty[i] = r_patch_v[i] && (r_sugar[i] == '0);
         if (harvest_req && harvest_patch == PW'(i) &&
             r_patch_v[i] && r_sugar[i] != '0 &&
             !(patch_wr && patch_id == PW'(i)))
            w_hok = 1'b1;
      end
   end

   // Placement writes win over same-slot harvest/deposit updates.
   always_ff @(posedge setup_clk) begin
      if (!RESET_SIM_n) begin
         r_nest_v  <= '0;
         r_nest_x  <= '0;
         r_nest_y  <= '0;
         r_food    <= '0;
         r_patch_v <= '0;
         r_patch_x <= '0;
         r_patch_y <= '0;
         r_sugar   <= '0;
         r_hack    <= 1'b0;
         r_hok     <= 1'b0;
      end else begin
         for (int i = 0; i < NEST_num; i++) begin
            if (nest_wr && nest_id == NW'(i)) begin
               r_nest_v[i] <= 1'b1;
               r_nest_x[i] <= nest_setup_x;
               r_nest_y[i] <= nest_setup_y;
               r_food[i]   <= '0;
            end else if (deposit_req && deposit_nest == NW'(i) &&
                         r_nest_v[i] && r_food[i] != F_MAX) begin
               r_food[i] <= r_food[i] + 1'b1;
            end
         end
         for (int i = 0; i < SUGARPATCH_num; i++) begin
            if (patch_wr && patch_id == PW'(i)) begin
               r_patch_v[i] <= 1'b1;
               r_patch_x[i] <= patch_setup_x;
               r_patch_y[i] <= patch_setup_y;
               r_sugar[i]   <= S_INIT;
            end else if (harvest_req && harvest_patch == PW'(i) &&
                         r_patch_v[i] && r_sugar[i] != '0) begin
               r_sugar[i] <= r_sugar[i] - 1'b1;
            end
         end
         r_hack <= harvest_req;
         r_hok  <= w_hok;
      end
   end

   assign collision   = w_coll;
   assign nests_X     = r_nest_x;
   assign nests_Y     = r_nest_y;
   assign nest_food   = r_food;
   assign patch_empty = w_empty;
   assign harvest_ack = r_hack;
   assign harvest_ok  = r_hok;

endmodule

// File: tb/tb_placement_registry.sv
// tb_placement_registry: directed vectors for placement_registry
// (collision probe, harvest/deposit counters, reset).
module tb_placement_registry;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              nest_wr;
   logic [1:0]        nest_id;
   logic [7:0]        nest_x;
   logic [6:0]        nest_y;
   logic              patch_wr;
   logic [2:0]        patch_id;
   logic [7:0]        patch_x;
   logic [6:0]        patch_y;
   logic [7:0]        cx;
   logic [6:0]        cy;
   logic              collision;
   logic [3:0][7:0]   nests_X;
   logic [3:0][6:0]   nests_Y;
   logic              h_req;
   logic [2:0]        h_patch;
   logic              h_ack;
   logic              h_ok;
   logic              d_req;
   logic [1:0]        d_nest;
   logic [7:0]        p_empty;
   logic [3:0][11:0]  food;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   placement_registry #(
      .NEST_num(4), .SUGARPATCH_num(8), .X_bits(8), .Y_bits(7),
      .COLLIDE_R(3), .SUGAR_bits(8), .SUGAR_init(2), .FOOD_bits(12)
   ) dut (
      .setup_clk(clk), .RESET_SIM_n(rst_n),
      .nest_wr(nest_wr), .nest_id(nest_id),
      .nest_setup_x(nest_x), .nest_setup_y(nest_y),
      .patch_wr(patch_wr), .patch_id(patch_id),
      .patch_setup_x(patch_x), .patch_setup_y(patch_y),
      .collide_x(cx), .collide_y(cy), .collision(collision),
      .nests_X(nests_X), .nests_Y(nests_Y),
      .harvest_req(h_req), .harvest_patch(h_patch),
      .harvest_ack(h_ack), .harvest_ok(h_ok),
      .deposit_req(d_req), .deposit_nest(d_nest),
      .patch_empty(p_empty), .nest_food(food)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string tag, input logic [7:0] x,
                        input logic [6:0] y, input logic exp);
      cx = x;
      cy = y;
      #1;
      chk(tag, 64'(collision), 64'(exp));
   endtask

   task automatic harvest1(input string tag, input logic [2:0] p,
                           input logic exp_ok);
      h_req   = 1'b1;
      h_patch = p;
      tick();
      h_req = 1'b0;
      chk({tag, "_ack"}, 64'(h_ack), 64'd1);
      chk({tag, "_ok"}, 64'(h_ok), 64'(exp_ok));
   endtask

   initial begin
      rst_n = 1'b0; nest_wr = 0; nest_id = 0; nest_x = 0; nest_y = 0;
      patch_wr = 0; patch_id = 0; patch_x = 0; patch_y = 0;
      cx = 0; cy = 0; h_req = 0; h_patch = 0; d_req = 0; d_nest = 0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_ack", 64'(h_ack), 64'd0);
      chk("rst_empty", 64'(p_empty), 64'd0);
      chk("rst_food", 64'(food), 64'd0);
      probe("rst_coll", 8'd0, 7'd0, 1'b0);

      // nest 0 at (10,20): invisible in write cycle, visible next
      nest_wr = 1; nest_id = 0; nest_x = 8'd10; nest_y = 7'd20;
      probe("coll_wr_cyc", 8'd13, 7'd23, 1'b0);
      tick();
      nest_wr = 0;
      probe("coll_next", 8'd13, 7'd23, 1'b1);
      probe("coll_dx4", 8'd14, 7'd20, 1'b0);
      probe("coll_lo_edge", 8'd7, 7'd17, 1'b1);
      probe("coll_dy4", 8'd10, 7'd24, 1'b0);
      chk("nestX0", 64'(nests_X[0]), 64'd10);
      chk("nestY0", 64'(nests_Y[0]), 64'd20);

      // patch 2 at (255,5): no wrap to x=0
      patch_wr = 1; patch_id = 2; patch_x = 8'd255; patch_y = 7'd5;
      tick();
      patch_wr = 0;
      probe("coll_nowrap", 8'd0, 7'd5, 1'b0);
      probe("coll_p2", 8'd252, 7'd8, 1'b1);

      // patch 1, back-to-back harvests with init sugar 2
      patch_wr = 1; patch_id = 1; patch_x = 8'd100; patch_y = 7'd100;
      tick();
      patch_wr = 0;
      chk("p1_full", 64'(p_empty[1]), 64'd0);
      h_req = 1; h_patch = 1;
      tick();
      chk("bb1_ack", 64'(h_ack), 64'd1);
      chk("bb1_ok", 64'(h_ok), 64'd1);
      tick();
      chk("bb2_ack", 64'(h_ack), 64'd1);
      chk("bb2_ok", 64'(h_ok), 64'd1);
      chk("p1_empty", 64'(p_empty[1]), 64'd1);
      tick();
      h_req = 0;
      chk("bb3_ack", 64'(h_ack), 64'd1);
      chk("bb3_ok", 64'(h_ok), 64'd0);
      tick();
      chk("ack_drop", 64'(h_ack), 64'd0);

      // unwritten patch 5
      harvest1("p5", 3'd5, 1'b0);
      chk("p5_empty", 64'(p_empty[5]), 64'd0);
      tick();
      chk("p5_ack_drop", 64'(h_ack), 64'd0);

      // patch 3: drain, then same-cycle write + harvest reloads
      patch_wr = 1; patch_id = 3; patch_x = 8'd40; patch_y = 7'd60;
      tick();
      patch_wr = 0;
      harvest1("p3a", 3'd3, 1'b1);
      harvest1("p3b", 3'd3, 1'b1);
      chk("p3_drained", 64'(p_empty[3]), 64'd1);
      patch_wr = 1; h_req = 1; h_patch = 3;
      tick();
      patch_wr = 0; h_req = 0;
      chk("wrh_ack", 64'(h_ack), 64'd1);
      chk("wrh_ok", 64'(h_ok), 64'd0);
      chk("wrh_full", 64'(p_empty[3]), 64'd0);
      harvest1("p3c", 3'd3, 1'b1);
      harvest1("p3d", 3'd3, 1'b1);
      chk("p3_redrained", 64'(p_empty[3]), 64'd1);

      // deposits: invalid nest ignored, same-cycle write resets
      d_req = 1; d_nest = 1;
      tick();
      chk("dep_invalid", 64'(food[1]), 64'd0);
      nest_wr = 1; nest_id = 1; nest_x = 8'd50; nest_y = 7'd50;
      tick();
      nest_wr = 0;
      chk("dep_wr_wins", 64'(food[1]), 64'd0);
      tick();
      chk("dep_one", 64'(food[1]), 64'd1);
      chk("dep_other", 64'(food[0]), 64'd0);
      repeat (4093) tick();
      chk("dep_4094", 64'(food[1]), 64'd4094);
      repeat (6) tick();
      d_req = 0;
      chk("dep_sat", 64'(food[1]), 64'd4095);

      // reset mid-run with a harvest pending
      rst_n = 0; h_req = 1; h_patch = 3;
      tick();
      rst_n = 1; h_req = 0;
      chk("mrst_ack", 64'(h_ack), 64'd0);
      chk("mrst_ok", 64'(h_ok), 64'd0);
      chk("mrst_nx", 64'(nests_X), 64'd0);
      chk("mrst_ny", 64'(nests_Y), 64'd0);
      chk("mrst_food", 64'(food), 64'd0);
      chk("mrst_empty", 64'(p_empty), 64'd0);
      probe("mrst_coll", 8'd10, 7'd20, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
